// File: rtl/axi_printf_initiator_pkg.sv
// Defaults and helpers for the printf write initiator.
// Character width is fixed at one byte; the AXI side carries it in wdata[7:0].
package axi_printf_initiator_pkg;
  import ravenoc_pkg::*;

  localparam int                        CHAR_W             = 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] PRINTF_ADDR_DFLT   = 32'h1000_0000;
  localparam logic [AXI_ID_WIDTH-1:0]   AXI_ID_DFLT        = '0;
  localparam int                        FIFO_DEPTH_DFLT    = 8;

  // A response is bad if the slave flagged an error or answered for another ID.
  function automatic logic bad_resp(input logic [1:0]              bresp,
                                    input logic [AXI_ID_WIDTH-1:0] bid,
                                    input logic [AXI_ID_WIDTH-1:0] exp_id);
    return (bresp != AXI_RESP_OKAY) || (bid != exp_id);
  endfunction
endpackage

// File: rtl/ravenoc_pkg.sv
// AXI4 bus widths, struct types and encodings shared by NoC master/slave ports.
// Bundles are split into master-driven (mosi) and slave-driven (miso) halves.
package ravenoc_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awqos;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
  } s_axi_miso_t;
endpackage

// File: rtl/axi_printf_initiator_char_fifo.sv
// Byte FIFO, DEPTH a power of 2; pop data is the head word, valid when !empty.
// Zero-latency read, push visible next cycle; full blocks push even on a same-cycle pop.
module printf_char_fifo
  import axi_printf_initiator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_dat,
  input  logic              pop,
  output logic [CHAR_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_dat;
  end
endmodule

// File: rtl/axi_printf_initiator.sv
// Buffers printf bytes and issues one single-beat AXI write per byte, waiting for B each time.
// Byte pushed in N is on AW/W in N+2; AW/W/B backpressure stalls the FSM, a full FIFO drops char_ready.
module axi_printf_initiator
  import ravenoc_pkg::*, axi_printf_initiator_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] PRINTF_ADDR = PRINTF_ADDR_DFLT,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID      = AXI_ID_DFLT,
  parameter int                        FIFO_DEPTH  = FIFO_DEPTH_DFLT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char_data,
  output logic              char_ready,
  output s_axi_mosi_t       axi_mosi,
  input  s_axi_miso_t       axi_miso,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RESP} state_t;

  state_t            state, state_nxt;
  logic [CHAR_W-1:0] data_ff, data_nxt;
  logic              aw_done, aw_done_nxt;
  logic              w_done, w_done_nxt;
  logic              err_ff, err_nxt;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_dat;
  logic              awvalid, wvalid, aw_hs, w_hs;
  logic              unused_miso;

  printf_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .arst     (arst),
    .push     (char_valid),
    .push_dat (char_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Valids depend only on registered state, never on the ready inputs.
  assign awvalid    = (state == ST_SEND) && !aw_done;
  assign wvalid     = (state == ST_SEND) && !w_done;
  assign aw_hs      = awvalid && axi_miso.awready;
  assign w_hs       = wvalid && axi_miso.wready;
  assign char_ready = !fifo_full;
  assign busy       = !fifo_empty || (state != ST_IDLE);
  assign err        = err_ff;

  assign unused_miso = ^{axi_miso.arready, axi_miso.rid, axi_miso.rdata,
                         axi_miso.rresp, axi_miso.rlast, axi_miso.rvalid};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= ST_IDLE;
      data_ff <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_ff  <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_ff <= data_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      err_ff  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    data_nxt    = data_ff;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    err_nxt     = err_ff;
    fifo_pop    = 1'b0;
    if (err_clr) err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          data_nxt    = fifo_dat;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        aw_done_nxt = aw_done || aw_hs;
        w_done_nxt  = w_done || w_hs;
        if (aw_done_nxt && w_done_nxt) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // Error set is evaluated after the clear so a coincident bad response wins.
        if (axi_miso.bvalid) begin
          if (bad_resp(axi_miso.bresp, axi_miso.bid, AXI_ID)) err_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload is only presented while in SEND, so everything reads 0 out of reset.
  always_comb begin
    axi_mosi = '0;
    if (state == ST_SEND) begin
      axi_mosi.awid    = AXI_ID;
      axi_mosi.awaddr  = PRINTF_ADDR;
      axi_mosi.awburst = AXI_BURST_INCR;
      axi_mosi.wdata   = {{(AXI_DATA_WIDTH-CHAR_W){1'b0}}, data_ff};
      axi_mosi.wstrb   = {{(AXI_DATA_WIDTH/8-1){1'b0}}, 1'b1};
      axi_mosi.wlast   = 1'b1;
    end
    axi_mosi.awvalid = awvalid;
    axi_mosi.wvalid  = wvalid;
    axi_mosi.bready  = (state == ST_RESP);
  end
endmodule

// File: doc/axi_printf_initiator.md
# axi_printf_initiator

AXI4 write initiator that turns a byte stream from a CPU-side or debug-side producer into single-beat AXI writes to the printf sink address. Characters are buffered in a small FIFO and drained one per transaction. Each transaction waits for the B response before the next one starts. The block sits on a NoC/AXI master port and is the transmitting end of the simulation printf path.

## Interface
- PRINTF_ADDR, 'h1000_0000: byte address driven on awaddr for every write.
- AXI_ID, 0: value driven on awid; expected on bid.
- FIFO_DEPTH, 8: character buffer depth. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock
- arst  in  1  reset arst, asynchronous, active-high; clock clk
- char_valid  in  1  producer has a character
- char_data  in  8  character
- char_ready  out  1  FIFO can accept; push when char_valid && char_ready
- axi_mosi  out  s_axi_mosi_t  AXI master outputs (ravenoc_pkg)
- axi_miso  in  s_axi_miso_t  AXI slave responses (ravenoc_pkg)
- busy  out  1  FIFO non-empty or FSM not IDLE
- err  out  1  sticky: bresp != OKAY or bid != AXI_ID seen
- err_clr  in  1  clears err; set wins if both occur in the same cycle

## Operation
- Fixed AW fields: awaddr=PRINTF_ADDR, awid=AXI_ID, awlen=0, awsize=0 (1 byte), awburst=INCR. All unused mosi fields are 0.
- W fields: wdata[7:0]=character, upper bits 0, wstrb=1, wlast=1.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into data_ff, clear aw_done/w_done, and go to SEND.
  - SEND: awvalid=!aw_done and wvalid=!w_done. Each channel is set done on its own handshake; AW and W may complete in either order or in the same cycle. When both are done, counting handshakes in the current cycle, go to RESP.
  - RESP: bready=1. On bvalid, check bresp and bid, update err, then go to IDLE.
- awvalid and wvalid, once asserted, stay asserted with stable payload until their handshake completes (AXI rule).
- bready is 0 outside RESP. A bvalid arriving outside RESP is ignored.
- Full FIFO: char_ready=0. There is no push-through on a full FIFO, even when a pop occurs in the same cycle.
- Empty FIFO: FSM stays in IDLE.
- Simultaneous push and pop in IDLE: both take effect and the count is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full when MSBs differ and the low bits are equal.
- Reset mid-operation abandons any in-flight transaction, empties the FIFO, and returns the FSM to IDLE.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from axi_miso to axi_mosi valid signals.
- Reset values: awvalid=0, wvalid=0, bready=0, all other mosi fields 0, char_ready=1, busy=0, err=0, FSM=IDLE, FIFO empty.
- A character pushed in cycle N is visible in cycle N+1, popped in IDLE in N+1, and driven with awvalid/wvalid in N+2.
- With awready=wready=1 and bvalid one cycle after the W beat, the sequence is RESP in N+3 and IDLE in N+4. Sustained throughput is one character per 3 cycles.
- Backpressure on AW or W extends SEND indefinitely. Backpressure on B extends RESP indefinitely.

## Structure
- AXI struct types and AXI_BURST_INCR / AXI_RESP_OKAY constants come from ravenoc_pkg. Add the constants there if they are absent.
- The FSM enum is local to the module.
- Sub-module printf_char_fifo: synchronous FIFO with parameter DEPTH, 8-bit width, and push/pop/full/empty signals, using asynchronous reset arst.

## Test plan
- Reset with arst=1 mid-SEND and release -> awvalid=0, wvalid=0, char_ready=1, busy=0, and no further AW handshake.
- Push "Hi\n" (0x48, 0x69, 0x0A) with a sink that is always ready and returns bvalid one cycle later -> 3 writes to PRINTF_ADDR, wdata 0x48/0x69/0x0A, wstrb=1, wlast=1, 3 cycles apart.
- awready held low 5 cycles while wready=1 -> W accepted first, awvalid held stable, RESP entered the cycle AW completes, then one B -> next character.
- Push 9 characters back-to-back with DEPTH=8 and bvalid stalled -> char_ready falls after the FIFO fills, no data lost, all 9 written in order after B resumes.
- Return bresp=SLVERR on one write -> err=1 sticky; err_clr pulse -> err=0; err_clr in the same cycle as another SLVERR -> err stays 1.
- Return bid=AXI_ID+1 -> err=1 and FSM still returns to IDLE.
